// File: rtl/masked_aes_seq_if.sv
// Handshake and register-file strobe bundle between the masked AES sequencer and its environment.
// master = sequencer side, slave = environment (register file, round/key units, RNG, host).
interface masked_aes_seq_if;
    logic         start;
    logic         abort;
    logic [3:0]   state_addr;
    logic [3:0]   key_addr;
    logic         rand_valid;
    logic         rand_ready;
    logic [127:0] rand_data;
    logic         round_req;
    logic         round_ack;
    logic [63:0]  round_data;
    logic [63:0]  key_next;
    logic [3:0]   rf_addr;
    logic [63:0]  rf_in0;
    logic [63:0]  rf_in1;
    logic [63:0]  rf_in2;
    logic         rf_write_en;
    logic         rf_read_en;
    logic         rf_random;
    logic         rf_add_round_key;
    logic         rf_aes_round;
    logic         rf_aes_key_exp;
    logic         busy;
    logic         done;
    logic [3:0]   round;

    modport master (
        input  start, abort, state_addr, key_addr, rand_valid, rand_data,
               round_ack, round_data, key_next,
        output rand_ready, round_req, rf_addr, rf_in0, rf_in1, rf_in2,
               rf_write_en, rf_read_en, rf_random, rf_add_round_key,
               rf_aes_round, rf_aes_key_exp, busy, done, round
    );

    modport slave (
        output start, abort, state_addr, key_addr, rand_valid, rand_data,
               round_ack, round_data, key_next,
        input  rand_ready, round_req, rf_addr, rf_in0, rf_in1, rf_in2,
               rf_write_en, rf_read_en, rf_random, rf_add_round_key,
               rf_aes_round, rf_aes_key_exp, busy, done, round
    );
endinterface

// File: rtl/masked_aes_seq.sv
// Control sequencer for one masked AES block operation on the 16 x 64-bit share register file.
// Strobes are decoded from the state register plus the same-cycle handshake inputs.
module masked_aes_seq #(
    parameter int unsigned NROUNDS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    masked_aes_seq_if.master  bus
);
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_MASK, S_ARK, S_RREQ, S_RWAIT, S_KEY, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] sbase, sbase_nxt, kbase, kbase_nxt;
    logic [AW-1:0] sbase_p2;

    // Round reads address the second half of the state shares; wraps within the 16-entry file.
    assign sbase_p2 = AW'(sbase + AW'(2));

    // State, round counter and latched base addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            sbase <= '0;
            kbase <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sbase <= sbase_nxt;
            kbase <= kbase_nxt;
        end
    end

    // Next state and strobe decode.
    always_comb begin
        state_nxt            = state;
        cnt_nxt              = cnt;
        sbase_nxt            = sbase;
        kbase_nxt            = kbase;
        bus.rand_ready       = 1'b0;
        bus.round_req        = 1'b0;
        bus.rf_addr          = '0;
        bus.rf_in0           = '0;
        bus.rf_in1           = '0;
        bus.rf_in2           = '0;
        bus.rf_write_en      = 1'b0;
        bus.rf_read_en       = 1'b0;
        bus.rf_random        = 1'b0;
        bus.rf_add_round_key = 1'b0;
        bus.rf_aes_round     = 1'b0;
        bus.rf_aes_key_exp   = 1'b0;
        bus.busy             = (state != S_IDLE);
        bus.done             = (state == S_DONE);
        bus.round            = cnt;

        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_MASK;
                    sbase_nxt = bus.state_addr;
                    kbase_nxt = bus.key_addr;
                end
            end
            S_MASK: begin
                bus.rand_ready = bus.rand_valid;
                if (bus.rand_valid) begin
                    bus.rf_write_en = 1'b1;
                    bus.rf_random   = 1'b1;
                    bus.rf_addr     = sbase;
                    bus.rf_in0      = DW'(sbase);
                    bus.rf_in1      = bus.rand_data[63:0];
                    bus.rf_in2      = bus.rand_data[127:64];
                    state_nxt       = S_ARK;
                end
            end
            S_ARK: begin
                bus.rf_write_en      = 1'b1;
                bus.rf_add_round_key = 1'b1;
                bus.rf_addr          = sbase;
                bus.rf_in0           = DW'(sbase);
                bus.rf_in1           = DW'(kbase);
                if (cnt == CW'(NROUNDS)) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt   = CW'(cnt + CW'(1));
                    state_nxt = S_RREQ;
                end
            end
            S_RREQ, S_RWAIT: begin
                bus.rf_read_en   = 1'b1;
                bus.rf_aes_round = 1'b1;
                bus.round_req    = 1'b1;
                bus.rf_addr      = sbase;
                bus.rf_in0       = DW'(sbase_p2);
                bus.rf_in1       = DW'(sbase);
                if (state == S_RREQ) begin
                    state_nxt = S_RWAIT;
                end else if (bus.round_ack) begin
                    bus.rf_write_en = 1'b1;
                    bus.rf_in2      = bus.round_data;
                    state_nxt       = S_KEY;
                end
            end
            S_KEY: begin
                bus.rf_read_en     = 1'b1;
                bus.rf_write_en    = 1'b1;
                bus.rf_aes_key_exp = 1'b1;
                bus.rf_addr        = kbase;
                bus.rf_in0         = DW'(kbase);
                bus.rf_in1         = DW'(kbase);
                bus.rf_in2         = bus.key_next;
                state_nxt          = S_ARK;
            end
            S_DONE: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Abort silences the register file and handshakes in the cycle it is seen.
        if (bus.abort && (state != S_IDLE)) begin
            state_nxt            = S_IDLE;
            cnt_nxt              = '0;
            bus.rand_ready       = 1'b0;
            bus.round_req        = 1'b0;
            bus.rf_addr          = '0;
            bus.rf_in0           = '0;
            bus.rf_in1           = '0;
            bus.rf_in2           = '0;
            bus.rf_write_en      = 1'b0;
            bus.rf_read_en       = 1'b0;
            bus.rf_random        = 1'b0;
            bus.rf_add_round_key = 1'b0;
            bus.rf_aes_round     = 1'b0;
            bus.rf_aes_key_exp   = 1'b0;
            bus.done             = 1'b0;
        end
    end
endmodule

// File: tb/tb_masked_aes_seq.sv
// Self-checking bench for masked_aes_seq: table-driven runs against a write-event scoreboard,
// plus hand-written abort and mid-run reset sequences.
module tb_masked_aes_seq;
    localparam int unsigned NR = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    masked_aes_seq_if bus ();
    masked_aes_seq #(.NROUNDS(NR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Expected register-file write: mode = {random, ark, round, key_exp}.
    typedef struct {
        logic [3:0]  mode;
        logic [63:0] in0, in1, in2;
        logic [3:0]  rnd;
        logic [3:0]  addr;
        bit          chk_addr;
    } wr_t;

    typedef struct {
        logic [3:0]  sa, ka;
        int          stall, dly_round, dly;
        bit          start_mid, ack_key;
        logic [63:0] m0, m1;
        int          exp_done;
    } vec_t;

    wr_t  sb[$];
    vec_t vecs[5];

    int checks = 0, errors = 0;
    int cyc = 0, done_cyc = -1, pre_ack = -1;
    bit armed = 0, done_seen = 0;
    int n_ark = 0, n_rnd = 0, n_key = 0;
    int dly_round = 0, dly = 0;
    bit ack_key = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [63:0] rdata(input logic [3:0] r);
        return (dly > 0 && int'(r) == dly_round) ? 64'hDEAD : 64'h1000 + 64'(r);
    endfunction

    function automatic logic [63:0] kdata(input logic [3:0] r);
        return 64'hC0DE_0000 + 64'(r);
    endfunction

    // Reference sequence of register-file writes for one full operation.
    task automatic push_op(input logic [3:0] sa, input logic [3:0] ka,
                           input logic [63:0] m0, input logic [63:0] m1);
        sb.push_back('{4'b1000, 64'(sa), m0, m1, 4'd0, sa, 1'b1});
        for (int r = 0; r <= int'(NR); r++) begin
            sb.push_back('{4'b0100, 64'(sa), 64'(ka), 64'd0, 4'(r), 4'd0, 1'b0});
            if (r < int'(NR)) begin
                sb.push_back('{4'b0010, 64'(4'(sa + 4'd2)), 64'(sa), rdata(4'(r + 1)),
                               4'(r + 1), 4'd0, 1'b0});
                sb.push_back('{4'b0001, 64'(ka), 64'(ka), kdata(4'(r + 1)),
                               4'(r + 1), 4'd0, 1'b0});
            end
        end
    endtask

    // Round-unit responder and output monitor.
    initial begin
        logic [3:0] modes;
        int reqcnt, need;
        bit resp_ack, prev_ack;
        wr_t e;
        reqcnt = 0; prev_ack = 0;
        bus.round_ack = 1'b0; bus.round_data = '0; bus.key_next = '0;
        forever begin
            @(negedge clk);
            reqcnt   = bus.round_req ? reqcnt + 1 : 0;
            need     = (dly > 0 && int'(bus.round) == dly_round) ? dly + 2 : 2;
            resp_ack = bus.round_req && (reqcnt >= need);
            bus.round_ack  = resp_ack || (ack_key && prev_ack);
            prev_ack       = resp_ack;
            bus.round_data = rdata(bus.round);
            bus.key_next   = kdata(bus.round);
            #1;
            if (rst_n) begin
                modes = {bus.rf_random, bus.rf_add_round_key, bus.rf_aes_round, bus.rf_aes_key_exp};
                if (armed) cyc++;
                if (bus.start && !bus.busy) begin armed = 1; cyc = 0; end
                check("mode_exclusive", 64'($countones(modes) <= 1), 64'd1);
                if (!bus.busy)
                    check("idle_quiet", 64'({modes, bus.rf_write_en, bus.rf_read_en, bus.round_req,
                                             bus.rand_ready, bus.done, bus.round}), 64'd0);
                if (resp_ack && dly > 0 && int'(bus.round) == dly_round) pre_ack = reqcnt - 1;
                if (bus.rf_write_en) begin
                    if (modes == 4'b0100) n_ark++;
                    if (modes == 4'b0010) n_rnd++;
                    if (modes == 4'b0001) n_key++;
                    if (sb.size() == 0) begin
                        check("unexpected_write", 64'(modes), 64'hF);
                    end else begin
                        e = sb.pop_front();
                        check("wr_mode", 64'(modes), 64'(e.mode));
                        check("wr_in0", bus.rf_in0, e.in0);
                        check("wr_in1", bus.rf_in1, e.in1);
                        check("wr_in2", bus.rf_in2, e.in2);
                        check("wr_round", 64'(bus.round), 64'(e.rnd));
                        if (e.chk_addr) check("wr_addr", 64'(bus.rf_addr), 64'(e.addr));
                    end
                end
                if (bus.done) begin
                    if (armed) done_cyc = cyc;
                    done_seen = 1; armed = 0;
                end
            end
        end
    end

    task automatic start_op(input vec_t v);
        dly_round = v.dly_round; dly = v.dly; ack_key = v.ack_key;
        n_ark = 0; n_rnd = 0; n_key = 0; done_cyc = -1; done_seen = 0; pre_ack = -1;
        push_op(v.sa, v.ka, v.m0, v.m1);
        @(negedge clk);
        bus.start = 1'b1; bus.state_addr = v.sa; bus.key_addr = v.ka;
        bus.rand_data = {v.m1, v.m0}; bus.rand_valid = (v.stall == 0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (v.stall) begin
            #2;
            check("stall_quiet", 64'({bus.rf_write_en, bus.rf_read_en, bus.rf_random,
                                      bus.rand_ready, bus.round_req}), 64'd0);
            @(negedge clk);
        end
        bus.rand_valid = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        start_op(v);
        for (int i = 0; i < 300 && !done_seen; i++) begin
            @(negedge clk);
            bus.start = v.start_mid && (i == 20);
        end
        bus.start = 1'b0;
        check("done_seen", 64'(done_seen), 64'd1);
        check("done_latency", 64'(done_cyc), 64'(v.exp_done));
        check("ark_writes", 64'(n_ark), 64'(NR + 1));
        check("round_writes", 64'(n_rnd), 64'(NR));
        check("key_writes", 64'(n_key), 64'(NR));
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        if (v.dly > 0) check("req_before_ack", 64'(pre_ack), 64'(v.dly + 1));
        repeat (2) @(negedge clk);
        sb.delete();
        dly = 0; ack_key = 0;
    endtask

    initial begin
        bit found;
        bus.start = 0; bus.abort = 0; bus.state_addr = '0; bus.key_addr = '0;
        bus.rand_valid = 0; bus.rand_data = '0;
        //          sa     ka    stall dr dly mid ak  m0                      m1                      done
        vecs[0] = '{4'd0,  4'd4, 0,    0, 0,  0,  0,  64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 43};
        vecs[1] = '{4'd0,  4'd4, 5,    0, 0,  0,  0,  64'hA,                   64'hB,                   48};
        vecs[2] = '{4'd0,  4'd4, 0,    2, 3,  0,  0,  64'h1111,                64'h2222,                46};
        vecs[3] = '{4'd14, 4'd8, 0,    0, 0,  0,  0,  64'h3333,                64'h4444,                43};
        vecs[4] = '{4'd14, 4'd8, 2,    7, 1,  1,  1,  64'h5555,                64'h6666,                46};

        #2;
        check("reset_ctrl", 64'({bus.rf_addr, bus.rf_write_en, bus.rf_read_en, bus.rf_random,
                                 bus.rf_add_round_key, bus.rf_aes_round, bus.rf_aes_key_exp,
                                 bus.rand_ready, bus.round_req, bus.busy, bus.done, bus.round}), 64'd0);
        check("reset_data", bus.rf_in0 | bus.rf_in1 | bus.rf_in2, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Abort while the round unit stalls in round 5.
        begin
            vec_t va;
            va = vecs[0]; va.dly_round = 5; va.dly = 50;
            start_op(va);
            found = 0;
            for (int i = 0; i < 200 && !found; i++) begin
                @(negedge clk); #2;
                if (bus.round == 4'd5 && bus.round_req) found = 1;
            end
            check("abort_reach_round5", 64'(found), 64'd1);
            repeat (2) @(negedge clk);
            bus.abort = 1'b1;
            #2;
            check("abort_cycle_quiet", 64'({bus.rf_write_en, bus.rf_read_en, bus.rf_aes_round,
                                            bus.round_req, bus.rand_ready, bus.done}), 64'd0);
            @(negedge clk);
            bus.abort = 1'b0;
            #2;
            check("abort_busy", 64'(bus.busy), 64'd0);
            check("abort_round", 64'(bus.round), 64'd0);
            repeat (10) @(negedge clk);
            check("abort_no_done", 64'(done_seen), 64'd0);
            sb.delete(); dly = 0;
            run_vec(vecs[0]);
        end

        // Asynchronous reset during a key-expansion cycle.
        start_op(vecs[3]);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk); #2;
            if (bus.rf_aes_key_exp) found = 1;
        end
        check("reset_reach_key", 64'(found), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ctrl", 64'({bus.rf_addr, bus.rf_write_en, bus.rf_read_en, bus.rf_random,
                                  bus.rf_add_round_key, bus.rf_aes_round, bus.rf_aes_key_exp,
                                  bus.rand_ready, bus.round_req, bus.busy, bus.done, bus.round}), 64'd0);
        check("midrst_data", bus.rf_in0 | bus.rf_in1 | bus.rf_in2, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
